// File: rtl/gpio_bidir_ctrl.sv
// Bidirectional GPIO bank with per-bit direction, registered output drive,
// input synchroniser, per-bit debounce and sticky edge capture with interrupt.
//
// Ports:
//   clk          system clock, all logic in this domain
//   rst_n        asynchronous active-low reset
//   dio_buf      pad signals (one tristate buffer per bit)
//   dout_i       data driven on output-mode bits
//   dir_i        per-bit direction, 1 = drive, 0 = hi-Z
//   din_o        debounced pad value for every bit (includes driven readback)
//   rise_en_i    per-bit rising-edge capture enable
//   fall_en_i    per-bit falling-edge capture enable
//   clr_i        write-1-to-clear pulse for both pending flags of a bit
//   rise_pend_o  sticky rising-edge flags
//   fall_pend_o  sticky falling-edge flags
//   irq_o        OR of all pending flags
module gpio_bidir_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CNT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] dio_buf,
    input  logic [WIDTH-1:0] dout_i,
    input  logic [WIDTH-1:0] dir_i,
    output logic [WIDTH-1:0] din_o,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] rise_pend_o,
    output logic [WIDTH-1:0] fall_pend_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] db_prev_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // ------------------------------------------------------------------
    // Drive path: registered data and enable, one tristate buffer per bit.
    // Reset clears oe_q asynchronously, so pads float without a clock edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            oe_q   <= '0;
        end else begin
            dout_q <= dout_i;
            oe_q   <= dir_i;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_iobuf
        assign dio_buf[i] = oe_q[i] ? dout_q[i] : 1'bz;
    end

    // ------------------------------------------------------------------
    // Input synchroniser. Output-mode bits are sampled too, giving readback.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= dio_buf;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: db only follows sync after DEBOUNCE_CNT consecutive cycles
    // of disagreement; any agreement restarts the count.
    // ------------------------------------------------------------------
    if (DEBOUNCE_CNT > 0) begin : g_debounce
        localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CNT - 1);

        logic [CNT_W-1:0] cnt_q [WIDTH];
        logic [CNT_W-1:0] cnt_d [WIDTH];

        always_comb begin
            db_d = db_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i] = '0;
                if (sync[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    db_d[i]  = sync[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end
    end else begin : g_bypass
        // Bypass keeps exactly one register stage after the synchroniser.
        assign db_d = sync;
    end

    // ------------------------------------------------------------------
    // Edge capture. Set has priority over a same-cycle clear.
    // db_prev_q resets to 0, so a pad high through reset yields one rise.
    // ------------------------------------------------------------------
    always_comb begin
        rise_d = (rise_q & ~clr_i) | (db_q & ~db_prev_q & rise_en_i);
        fall_d = (fall_q & ~clr_i) | (~db_q & db_prev_q & fall_en_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= '0;
            db_prev_q <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign din_o       = db_q;
    assign rise_pend_o = rise_q;
    assign fall_pend_o = fall_q;
    assign irq_o       = |(rise_q | fall_q);

endmodule

// File: tb/tb_gpio_bidir_ctrl.sv
// Self-checking bench for gpio_bidir_ctrl: a debounced instance with default
// parameters and a bypass instance (SYNC_STAGES = 3, DEBOUNCE_CNT = 0).
module tb_gpio_bidir_ctrl;

    logic       clk;
    logic       rst_n;

    // Debounced instance
    wire  [7:0] pad;
    logic [7:0] tb_en, tb_val;
    logic [7:0] dout, dir, ren, fen, clr;
    logic [7:0] din, rise_p, fall_p;
    logic       irq;

    // Bypass instance
    wire  [7:0] pad2;
    logic [7:0] tb2_val;
    logic [7:0] dout2, dir2, ren2, fen2, clr2;
    logic [7:0] din2, rise_p2, fall_p2;
    logic       irq2;

    int n_checks = 0;
    int n_err    = 0;

    for (genvar i = 0; i < 8; i++) begin : g_pad
        assign pad[i]  = tb_en[i] ? tb_val[i] : 1'bz;
        assign pad2[i] = tb2_val[i];
    end

    gpio_bidir_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dio_buf     (pad),
        .dout_i      (dout),
        .dir_i       (dir),
        .din_o       (din),
        .rise_en_i   (ren),
        .fall_en_i   (fen),
        .clr_i       (clr),
        .rise_pend_o (rise_p),
        .fall_pend_o (fall_p),
        .irq_o       (irq)
    );

    gpio_bidir_ctrl #(
        .WIDTH        (8),
        .SYNC_STAGES  (3),
        .DEBOUNCE_CNT (0),
        .CNT_W        (16)
    ) u_byp (
        .clk         (clk),
        .rst_n       (rst_n),
        .dio_buf     (pad2),
        .dout_i      (dout2),
        .dir_i       (dir2),
        .din_o       (din2),
        .rise_en_i   (ren2),
        .fall_en_i   (fen2),
        .clr_i       (clr2),
        .rise_pend_o (rise_p2),
        .fall_pend_o (fall_p2),
        .irq_o       (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic [7:0] ren;
        logic [7:0] fen;
        logic [7:0] clr;
        int         cyc;
        logic [7:0] din;
        logic [7:0] rp;
        logic [7:0] fp;
        logic       irq;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Edge-enable / clear / latency vectors, starting from pad = din = 0, no flags
        tbl[0]  = '{8'h08, 8'h00, 8'h08, 8'h00, 20, 8'h08, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{8'h00, 8'h00, 8'h08, 8'h00, 20, 8'h00, 8'h00, 8'h08, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 8'h00, 8'h00,  2, 8'h00, 8'h00, 8'h08, 1'b1};
        tbl[3]  = '{8'h00, 8'h00, 8'h00, 8'h08,  1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 8'h00, 8'h00,  1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{8'h06, 8'h06, 8'h06, 8'h00, 19, 8'h06, 8'h06, 8'h00, 1'b1};
        tbl[6]  = '{8'h06, 8'h06, 8'h06, 8'h04,  1, 8'h06, 8'h02, 8'h00, 1'b1};
        tbl[7]  = '{8'h00, 8'h06, 8'h06, 8'h00, 19, 8'h00, 8'h02, 8'h06, 1'b1};
        tbl[8]  = '{8'h00, 8'h06, 8'h06, 8'hFF,  1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{8'hF0, 8'hF0, 8'h00, 8'h00, 18, 8'hF0, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{8'hF0, 8'hF0, 8'h00, 8'h00,  1, 8'hF0, 8'hF0, 8'h00, 1'b1};
        tbl[11] = '{8'hF0, 8'hF0, 8'h00, 8'hFF,  1, 8'hF0, 8'h00, 8'h00, 1'b0};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 20, 8'h00, 8'h00, 8'h00, 1'b0};

        // ---------------- Reset / hi-Z ----------------
        rst_n  = 1'b0;
        tb_en  = 8'hFF;
        tb_val = 8'hA5;
        dout   = 8'h00;
        dir    = 8'h00;
        ren    = 8'h0F;
        fen    = 8'h00;
        clr    = 8'h00;
        tb2_val = 8'h00;
        dout2  = 8'h00;
        dir2   = 8'h00;
        ren2   = 8'hFF;
        fen2   = 8'hFF;
        clr2   = 8'h00;
        repeat (3) tick();
        check("rst_pad",   pad, 8'hA5);
        check("rst_din",   din, 8'h00);
        check("rst_rise",  rise_p, 8'h00);
        check("rst_fall",  fall_p, 8'h00);
        check("rst_irq",   irq, 1'b0);
        check("rst_din2",  din2, 8'h00);
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 17) check("rel_din_early", din, 8'h00);
            if (k == 18) check("rel_din", din, 8'hA5);
            if (k == 18) check("rel_rise_early", rise_p, 8'h00);
            if (k == 19) begin
                check("rel_rise", rise_p, 8'h05);
                check("rel_fall", fall_p, 8'h00);
                check("rel_irq",  irq, 1'b1);
            end
        end
        clr = 8'hFF;
        tick();
        clr = 8'h00;
        check("rel_clr_rise", rise_p, 8'h00);
        check("rel_clr_irq",  irq, 1'b0);

        ren    = 8'h00;
        tb_val = 8'h00;
        repeat (20) tick();
        check("settle0_din", din, 8'h00);

        // ---------------- Drive / readback ----------------
        dir  = 8'hFF;
        dout = 8'h3C;
        tick();
        tb_en = 8'h00;
        #1;
        check("drv_pad", pad, 8'h3C);
        for (int k = 2; k <= 19; k++) begin
            tick();
            if (k == 18) check("drv_din_early", din, 8'h00);
            if (k == 19) check("drv_din", din, 8'h3C);
        end
        dir = 8'h0F;
        check("dir_latency", pad, 8'h3C);
        tick();
        tb_val = 8'hA0;
        tb_en  = 8'hF0;
        #1;
        check("hiz_upper", pad, 8'hAC);
        dir = 8'h00;
        tick();
        tb_val = 8'h00;
        tb_en  = 8'hFF;
        repeat (20) tick();
        check("settle1_din", din, 8'h00);
        check("settle1_irq", irq, 1'b0);

        // ---------------- Debounce rejection ----------------
        ren = 8'h01;
        tb_val = 8'h01;
        repeat (15) tick();
        tb_val = 8'h00;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 25; k++) begin
                tick();
                if (din[0]) seen = 1'b1;
            end
            check("glitch15_din", {31'd0, seen}, 32'd0);
        end
        check("glitch15_rise", rise_p, 8'h00);

        tb_val = 8'h01;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 16) tb_val = 8'h00;
            if (k == 17) check("pulse16_din_early", din, 8'h00);
            if (k == 18) begin
                check("pulse16_din", din, 8'h01);
                check("pulse16_rise_early", rise_p, 8'h00);
            end
            if (k == 19) begin
                check("pulse16_rise", rise_p, 8'h01);
                check("pulse16_irq", irq, 1'b1);
            end
        end
        repeat (20) tick();
        check("pulse16_fall_din", din, 8'h00);
        clr = 8'h01;
        tick();
        clr = 8'h00;
        check("pulse16_clr", rise_p, 8'h00);

        // ---------------- Table-driven edge capture ----------------
        for (int v = 0; v < 13; v++) begin
            tb_val = tbl[v].val;
            ren    = tbl[v].ren;
            fen    = tbl[v].fen;
            clr    = tbl[v].clr;
            repeat (tbl[v].cyc) tick();
            check($sformatf("vec%0d_pad",  v), pad,    tbl[v].val);
            check($sformatf("vec%0d_din",  v), din,    tbl[v].din);
            check($sformatf("vec%0d_rise", v), rise_p, tbl[v].rp);
            check($sformatf("vec%0d_fall", v), fall_p, tbl[v].fp);
            check($sformatf("vec%0d_irq",  v), irq,    tbl[v].irq);
        end
        clr = 8'h00;

        // ---------------- Bypass instance: 1-cycle pulse ----------------
        tb2_val = 8'h01;
        tick();
        tb2_val = 8'h00;
        for (int k = 2; k <= 6; k++) begin
            tick();
            if (k == 3) check("byp_din_early", din2, 8'h00);
            if (k == 4) check("byp_din", din2, 8'h01);
            if (k == 5) begin
                check("byp_din_width", din2, 8'h00);
                check("byp_rise", rise_p2, 8'h01);
                check("byp_fall_early", fall_p2, 8'h00);
            end
            if (k == 6) begin
                check("byp_fall", fall_p2, 8'h01);
                check("byp_irq", irq2, 1'b1);
            end
        end

        // ---------------- Set/clear collision ----------------
        ren    = 8'h02;
        fen    = 8'h00;
        tb_val = 8'h02;
        repeat (18) tick();
        clr = 8'h02;
        tick();
        clr = 8'h00;
        check("collide_rise", rise_p, 8'h02);
        check("collide_irq",  irq, 1'b1);

        // ---------------- Asynchronous reset mid-cycle ----------------
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_din",   din, 8'h00);
        check("async_rise",  rise_p, 8'h00);
        check("async_irq",   irq, 1'b0);
        check("async_rise2", rise_p2, 8'h00);
        check("async_irq2",  irq2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
